// File: rtl/cnn_line_bank_pkg.sv
// Default geometry, bank-index width helper and pixel type for cnn_line_bank.
package cnn_line_bank_pkg;
  localparam int unsigned DATA_W_DEF = 21;
  localparam int unsigned CH_DEF     = 3;
  localparam int unsigned BANKS_DEF  = 4;
  localparam int unsigned LINE_W_DEF = 28;
  localparam int unsigned IMG_H_DEF  = 28;
  localparam int unsigned ADDR_W_DEF = 11;
  localparam int unsigned WIN_DEF    = 3;
  localparam int unsigned STRIDE_DEF = 2;

  function automatic int unsigned bank_w(input int unsigned n);
    return (n <= 1) ? 32'd1 : 32'($clog2(n));
  endfunction

  typedef logic [CH_DEF-1:0][DATA_W_DEF-1:0] pixel_t;
endpackage

// File: rtl/cnn_line_bank_ram.sv
// One row bank: simple dual-port, read-first, rd_en-gated registered read.
// CNN_LINE_BANK_PAD_EN: reads at rd_addr >= DEPTH return zero without touching memory.
module cnn_line_bank_ram #(
  parameter int unsigned W      = 63,
  parameter int unsigned DEPTH  = 28,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [W-1:0]      wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [W-1:0]      rd_data
);
  localparam int unsigned MW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [MW-1:0] wr_idx;
  logic [MW-1:0] rd_idx;
  logic          unused_addr_hi;

  // The writer never issues an out-of-range address, so the high bits only matter for padding.
  assign wr_idx         = wr_addr[MW-1:0];
  assign rd_idx         = rd_addr[MW-1:0];
  assign unused_addr_hi = ^{wr_addr[ADDR_W-1:MW], rd_addr[ADDR_W-1:MW]};

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      rd_data <= '0;
    end else if (rd_en) begin
`ifdef CNN_LINE_BANK_PAD_EN
      if (rd_addr >= ADDR_W'(DEPTH)) rd_data <= '0;
      else                           rd_data <= mem[rd_idx];
`else
      rd_data <= mem[rd_idx];
`endif
    end
  end
endmodule

// File: rtl/cnn_line_bank.sv
// Multi-channel CNN line buffer: round-robin row banks with occupancy tracking and window-ready pulses.
// Optional zero padding of out-of-range reads via CNN_LINE_BANK_PAD_EN.
module cnn_line_bank
  import cnn_line_bank_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CH     = CH_DEF,
  parameter int unsigned BANKS  = BANKS_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned WIN    = WIN_DEF,
  parameter int unsigned STRIDE = STRIDE_DEF
) (
  input  logic                          clk,
  input  logic                          RESET,
  input  logic                          start_wr,
  input  logic                          de_in,
  input  logic [CH*DATA_W-1:0]          in_data,
  input  logic [BANKS-1:0]              rd_en,
  input  logic [ADDR_W-1:0]             rd_addr,
  input  logic                          rd_release,
  output logic [BANKS*CH*DATA_W-1:0]    q_out,
  output logic                          de_out,
  output logic                          rows_ready,
  output logic                          bank_toggle,
  output logic [bank_w(BANKS)-1:0]      oldest_bank,
  output logic [bank_w(BANKS):0]        filled,
  output logic                          frame_done,
  output logic                          overflow
);
  localparam int unsigned PW = CH * DATA_W;
  localparam int unsigned BW = bank_w(BANKS);
  localparam int unsigned RW = $clog2(IMG_H + 1);

  logic [ADDR_W-1:0] wr_addr;
  logic [BW-1:0]     wr_bank;
  logic [RW-1:0]     row_cnt;
  logic              de_prev;
  logic              row_acc;

  logic              row_start_c;
  logic              row_end_c;
  logic              room_c;
  logic              row_ok_c;
  logic              in_range_c;
  logic              wr_en_c;
  logic              ovf_c;
  logic [RW-1:0]     rows_next_c;
  logic              frame_end_c;
  logic              ready_c;
  logic [BW+1:0]     fill_sum_c;
  logic [BW:0]       filled_nxt_c;
  logic [BW:0]       old_sum_c;
  logic [BW-1:0]     oldest_nxt_c;
  logic [BW-1:0]     wr_bank_nxt_c;

  // Row framing, acceptance and next-value computation.
  always_comb begin
    row_start_c   = start_wr & de_in & ~de_prev;
    row_end_c     = start_wr & ~de_in & de_prev & row_acc;
    room_c        = filled < (BW+1)'(BANKS);
    row_ok_c      = row_start_c ? room_c : row_acc;
    in_range_c    = wr_addr < ADDR_W'(LINE_W);
    wr_en_c       = start_wr & de_in & row_ok_c & in_range_c;
    ovf_c         = (row_start_c & ~room_c) | (start_wr & de_in & row_ok_c & ~in_range_c);
    rows_next_c   = RW'(row_cnt + 1'b1);
    frame_end_c   = row_end_c & (rows_next_c == RW'(IMG_H));
    ready_c       = row_end_c && (32'(rows_next_c) >= WIN) &&
                    (((32'(rows_next_c) - WIN) % STRIDE) == 32'd0);
    wr_bank_nxt_c = (wr_bank == BW'(BANKS - 1)) ? '0 : BW'(wr_bank + 1'b1);

    fill_sum_c    = (BW+2)'(filled) + (BW+2)'(row_end_c);
    filled_nxt_c  = (BW+1)'(fill_sum_c);
    if (rd_release) begin
      filled_nxt_c = (fill_sum_c >= (BW+2)'(STRIDE)) ? (BW+1)'(fill_sum_c - (BW+2)'(STRIDE)) : '0;
    end

    old_sum_c     = (BW+1)'(oldest_bank) + (BW+1)'(STRIDE);
    oldest_nxt_c  = (old_sum_c >= (BW+1)'(BANKS)) ? BW'(old_sum_c - (BW+1)'(BANKS)) : BW'(old_sum_c);
  end

  // de_prev follows de_in even in reset so a row in flight is ignored until it ends.
  always_ff @(posedge clk) begin
    de_prev <= de_in;
    if (RESET) begin
      wr_addr     <= '0;
      wr_bank     <= '0;
      row_cnt     <= '0;
      row_acc     <= 1'b0;
      de_out      <= 1'b0;
      rows_ready  <= 1'b0;
      bank_toggle <= 1'b0;
      oldest_bank <= '0;
      filled      <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      de_out     <= start_wr & de_in;
      rows_ready <= ready_c;
      frame_done <= frame_end_c;
      if (ovf_c) overflow <= 1'b1;
      if (!start_wr) begin
        wr_addr     <= '0;
        wr_bank     <= '0;
        row_cnt     <= '0;
        row_acc     <= 1'b0;
        bank_toggle <= 1'b0;
        oldest_bank <= '0;
        filled      <= '0;
      end else begin
        bank_toggle <= bank_toggle ^ ready_c;
        if (row_start_c) row_acc <= room_c;
        if (wr_en_c) wr_addr <= ADDR_W'(wr_addr + 1'b1);
        if (frame_end_c) begin
          wr_addr     <= '0;
          wr_bank     <= '0;
          row_cnt     <= '0;
          oldest_bank <= '0;
          filled      <= '0;
        end else begin
          if (row_end_c) begin
            wr_addr <= '0;
            wr_bank <= wr_bank_nxt_c;
            row_cnt <= rows_next_c;
          end
          filled <= filled_nxt_c;
          if (rd_release) oldest_bank <= oldest_nxt_c;
        end
      end
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    cnn_line_bank_ram #(
      .W      (PW),
      .DEPTH  (LINE_W),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk     (clk),
      .RESET   (RESET),
      .wr_en   (wr_en_c && (wr_bank == BW'(b))),
      .wr_addr (wr_addr),
      .wr_data (in_data),
      .rd_en   (rd_en[b]),
      .rd_addr (rd_addr),
      .rd_data (q_out[b*PW +: PW])
    );
  end
endmodule
